// File: rtl/div_pkg.sv
// Shared definitions for the sequential MIPS divider: FSM state encoding
// and the iteration-counter width helper.
package div_pkg;

   // Divider control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } div_state_t;

   // Counter must hold values 0..nbit, hence clog2(nbit+1) bits
   function automatic int cnt_width(input int nbit);
      return $clog2(nbit + 1);
   endfunction

   localparam int DEFAULT_NBIT = 32;
   localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_NBIT);

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate. Used to form operand magnitudes on
// entry and to restore result signs at the end of a divide.
module div_abs_neg #(
   parameter int NBit = 32
) (
   input  logic [NBit-1:0] i_val,
   input  logic            i_neg,
   output logic [NBit-1:0] o_val
);

   // Negation wraps, so the most-negative value maps onto itself, which is
   // exactly its unsigned magnitude
   assign o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/mips_div_unit.sv
// Sequential DIV/DIVU unit: one quotient bit per clock using non-restoring
// division on magnitudes, with sign fix-up, abort, divide-by-zero
// reporting and registered results that hold between completions.
module mips_div_unit
   import div_pkg::*;
#(
   parameter int NBit = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic            i_signed,
   input  logic [NBit-1:0] i_dividend,
   input  logic [NBit-1:0] i_divisor,
   input  logic            i_abort,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_div_zero,
   output logic [NBit-1:0] o_quotient,
   output logic [NBit-1:0] o_remainder
);

   localparam int CW = cnt_width(NBit);

   div_state_t      r_state;
   logic [CW-1:0]   r_cnt;
   logic [NBit:0]   r_prem;     // signed partial remainder, one guard bit
   logic [NBit-1:0] r_quo;      // dividend magnitude shifting out, quotient shifting in
   logic [NBit-1:0] r_dvsr;     // divisor magnitude
   logic            r_qneg;
   logic            r_rneg;
   logic            r_busy;
   logic            r_done;
   logic            r_div_zero;
   logic [NBit-1:0] r_quotient;
   logic [NBit-1:0] r_remainder;

   logic [NBit:0]   w_prem_sh;
   logic [NBit:0]   w_prem_step;
   logic [NBit-1:0] w_rem_mag;

   // Negator bank: [0] dividend magnitude, [1] divisor magnitude,
   // [2] signed quotient, [3] signed remainder
   logic [NBit-1:0] w_neg_in  [4];
   logic            w_neg_en  [4];
   logic [NBit-1:0] w_neg_out [4];

   assign w_neg_in[0] = i_dividend;
   assign w_neg_en[0] = i_signed & i_dividend[NBit-1];
   assign w_neg_in[1] = i_divisor;
   assign w_neg_en[1] = i_signed & i_divisor[NBit-1];
   assign w_neg_in[2] = r_quo;
   assign w_neg_en[2] = r_qneg;
   assign w_neg_in[3] = w_rem_mag;
   assign w_neg_en[3] = r_rneg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_neg
         div_abs_neg #(.NBit(NBit)) u_neg (
            .i_val (w_neg_in[gi]),
            .i_neg (w_neg_en[gi]),
            .o_val (w_neg_out[gi])
         );
      end
   endgenerate

   // One non-restoring step: shift the next dividend bit in, then add or
   // subtract the divisor depending on the current remainder sign. The
   // true result always fits in NBit+1 bits, so the wrapped sum is exact.
   assign w_prem_sh   = {r_prem[NBit-1:0], r_quo[NBit-1]};
   assign w_prem_step = r_prem[NBit] ? (w_prem_sh + {1'b0, r_dvsr})
                                     : (w_prem_sh - {1'b0, r_dvsr});

   // Final remainder restore: a negative partial remainder gets one add-back
   assign w_rem_mag = r_prem[NBit] ? (r_prem[NBit-1:0] + r_dvsr) : r_prem[NBit-1:0];

   // Divider FSM with registered handshake and result outputs
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_prem      <= '0;
         r_quo       <= '0;
         r_dvsr      <= '0;
         r_qneg      <= 1'b0;
         r_rneg      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Abort beats Start even when the unit is idle
               if (i_start && !i_abort) begin
                  if (i_divisor == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= i_dividend;
                     r_div_zero  <= 1'b1;
                     r_done      <= 1'b1;
                  end else begin
                     r_state <= ST_ITER;
                     r_busy  <= 1'b1;
                     r_cnt   <= '0;
                     r_prem  <= '0;
                     r_quo   <= w_neg_out[0];
                     r_dvsr  <= w_neg_out[1];
                     r_qneg  <= i_signed & (i_dividend[NBit-1] ^ i_divisor[NBit-1]);
                     r_rneg  <= i_signed & i_dividend[NBit-1];
                  end
               end
            end
            ST_ITER: begin
               if (i_abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_prem <= w_prem_step;
                  r_quo  <= {r_quo[NBit-2:0], ~w_prem_step[NBit]};
                  r_cnt  <= r_cnt + 1'b1;
                  if (r_cnt == CW'(NBit - 1)) begin
                     r_state <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               if (!i_abort) begin
                  r_quotient  <= w_neg_out[2];
                  r_remainder <= w_neg_out[3];
                  r_div_zero  <= 1'b0;
                  r_done      <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_div_zero  = r_div_zero;
   assign o_quotient  = r_quotient;
   assign o_remainder = r_remainder;

endmodule
